// File: rtl/unary_sweep_checker.sv
// Exhaustive self-checker for a unary-operator DUT: sweeps every SIZE-bit operand,
// compares the six DUT results with 4-state case-inequality and logs failures.
module unary_sweep_checker #(
    parameter int unsigned SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            hold,
    output logic [SIZE-1:0] stim,
    input  logic [SIZE-1:0] in_bitnot,
    input  logic [SIZE-1:0] in_minus,
    input  logic            in_lognot,
    input  logic            in_and,
    input  logic            in_or,
    input  logic            in_xor,
    output logic            busy,
    output logic            done,
    output logic [15:0]     err_count,
    output logic            first_fail_valid,
    output logic [SIZE-1:0] first_fail_stim
);

    typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

    localparam logic [SIZE-1:0] StimMax = '1;

    state_e          state_q, state_d;
    logic [SIZE-1:0] stim_q, stim_d;
    logic [15:0]     err_q, err_d;
    logic            ffv_q, ffv_d;
    logic [SIZE-1:0] ffs_q, ffs_d;

    logic [SIZE-1:0] exp_bitnot;
    logic [SIZE-1:0] exp_minus;
    logic            mismatch;
    logic            restart;
    logic            step;

    // Case-inequality so X/Z on any DUT result is flagged as a failure.
    always_comb begin
        exp_bitnot = ~stim_q;
        exp_minus  = ~stim_q + SIZE'(1);
        mismatch   = (in_bitnot !== exp_bitnot)
                   | (in_minus  !== exp_minus)
                   | (in_lognot !== (stim_q == '0))
                   | (in_and    !== (&stim_q))
                   | (in_or     !== (|stim_q))
                   | (in_xor    !== (^stim_q));
    end

    assign restart = start && (state_q != StSweep);
    assign step    = (state_q == StSweep) && !hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StSweep;
            StSweep: if (!hold && stim_q == StimMax) state_d = StDone;
            StDone:  if (start) state_d = StSweep;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q <= '0;
            err_q  <= '0;
            ffv_q  <= 1'b0;
            ffs_q  <= '0;
        end else begin
            stim_q <= stim_d;
            err_q  <= err_d;
            ffv_q  <= ffv_d;
            ffs_q  <= ffs_d;
        end
    end

    always_comb begin
        stim_d = stim_q;
        err_d  = err_q;
        ffv_d  = ffv_q;
        ffs_d  = ffs_q;
        if (restart) begin
            stim_d = '0;
            err_d  = '0;
            ffv_d  = 1'b0;
            ffs_d  = '0;
        end else if (step) begin
            if (mismatch) begin
                err_d = err_q + 16'd1;
                if (!ffv_q) begin
                    ffv_d = 1'b1;
                    ffs_d = stim_q;
                end
            end
            // Final operand stays on stim while in DONE.
            if (stim_q != StimMax) begin
                stim_d = stim_q + SIZE'(1);
            end
        end
    end

    always_comb begin
        busy             = (state_q == StSweep);
        done             = (state_q == StDone);
        stim             = stim_q;
        err_count        = err_q;
        first_fail_valid = ffv_q;
        first_fail_stim  = ffs_q;
    end

endmodule
